// File: rtl/bmp_ram_arbiter_pkg.sv
// Shared constants for the BMP RAM write path: geometry of one image and
// the RAM port widths. These stand in for the DEFINE.vh macros ADDR_WIDTH,
// BYTE_WIDTH, BMP_TOTAL_SIZE and BMP_HDR_SIZE.
`timescale 1ns/1ps

package bmp_ram_arbiter_pkg;

  // RAM port geometry
  localparam int ADDR_WIDTH = 10;
  localparam int BYTE_WIDTH = 8;

  // Image geometry: 54-byte BMP header followed by 24-bit pixels
  localparam int BMP_HDR_SIZE   = 54;
  localparam int BMP_WIDTH      = 16;
  localparam int BMP_HEIGHT     = 16;
  localparam int BMP_TOTAL_SIZE = BMP_HDR_SIZE + BMP_WIDTH * BMP_HEIGHT * 3;

endpackage

// File: rtl/bmp_ram_arbiter.sv
// Two-requester write arbiter in front of the BMP RAM. The header and pixel
// producers are arbitrated round-robin. Each accepted write lands on the RAM
// port one cycle later. A pass ends after TOTAL in-range writes. Writes that
// fall outside the image are still accepted, so no producer can stall, but
// they are dropped and reported through the sticky err_oob flag.
`timescale 1ns/1ps

module bmp_ram_arbiter
  import bmp_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_WIDTH,
  parameter int DATA_W     = BYTE_WIDTH,
  parameter int TOTAL      = BMP_TOTAL_SIZE,
  parameter int PIX_OFFSET = BMP_HDR_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hdr_valid,
  output logic              hdr_ready,
  input  logic [ADDR_W-1:0] hdr_addr,
  input  logic [DATA_W-1:0] hdr_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic [DATA_W-1:0] pix_data,
  output logic              RAM_valid,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic [DATA_W-1:0] RAM_D,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              done,
  output logic              err_oob
);

  // Pass sequencing states, local to this block
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Image limits widened to the one-bit-wider target address width
  localparam logic [ADDR_W:0] TOTAL_W  = (ADDR_W+1)'(TOTAL);
  localparam logic [ADDR_W:0] LAST_W   = (ADDR_W+1)'(TOTAL - 1);
  localparam logic [ADDR_W:0] OFFSET_W = (ADDR_W+1)'(PIX_OFFSET);

  state_t            state;
  logic              favour_pix;
  logic              hdr_xfer;
  logic              pix_xfer;
  logic              xfer;
  logic              in_range;
  logic              write_fire;
  logic [ADDR_W:0]   target;
  logic [DATA_W-1:0] grant_data;

  // Round-robin grant, target address and range check for the current cycle
  always_comb begin
    hdr_ready  = 1'b0;
    pix_ready  = 1'b0;
    target     = '0;
    grant_data = '0;
    if (state == RUN) begin
      hdr_ready = hdr_valid && (!pix_valid || !favour_pix);
      pix_ready = pix_valid && (!hdr_valid ||  favour_pix);
    end
    hdr_xfer = hdr_valid && hdr_ready;
    pix_xfer = pix_valid && pix_ready;
    xfer     = hdr_xfer || pix_xfer;
    if (hdr_xfer) begin
      target     = {1'b0, hdr_addr};
      grant_data = hdr_data;
    end else begin
      target     = {1'b0, pix_addr} + OFFSET_W;
      grant_data = pix_data;
    end
    in_range   = target < TOTAL_W;
    write_fire = xfer && in_range;
  end

  // Pass FSM plus the registered RAM port, write counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      favour_pix <= 1'b0;
      RAM_valid  <= 1'b0;
      RAM_addr   <= '0;
      RAM_D      <= '0;
      wr_cnt     <= '0;
      done       <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      RAM_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            favour_pix <= 1'b0;
            wr_cnt     <= '0;
            done       <= 1'b0;
            err_oob    <= 1'b0;
          end
        end
        RUN: begin
          if (xfer) begin
            favour_pix <= hdr_xfer;
          end
          if (xfer && !in_range) begin
            err_oob <= 1'b1;
          end
          if (write_fire) begin
            RAM_valid <= 1'b1;
            RAM_addr  <= target[ADDR_W-1:0];
            RAM_D     <= grant_data;
            if (wr_cnt != TOTAL_W) begin
              wr_cnt <= wr_cnt + 1'b1;
            end
            if (wr_cnt == LAST_W) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_ram_arbiter.sv
// Directed self-checking bench for bmp_ram_arbiter using the default
// 16x16x24-bit image (822 bytes, 54-byte header, 10-bit addresses).
`timescale 1ns/1ps

module tb_bmp_ram_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int TOTAL = 822;
  localparam int HDR   = 54;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          hdr_valid;
  logic          hdr_ready;
  logic [AW-1:0] hdr_addr;
  logic [DW-1:0] hdr_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [AW-1:0] pix_addr;
  logic [DW-1:0] pix_data;
  logic          RAM_valid;
  logic [AW-1:0] RAM_addr;
  logic [DW-1:0] RAM_D;
  logic [AW:0]   wr_cnt;
  logic          done;
  logic          err_oob;

  int n_checks = 0;
  int n_fail   = 0;

  bmp_ram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hdr_valid (hdr_valid),
    .hdr_ready (hdr_ready),
    .hdr_addr  (hdr_addr),
    .hdr_data  (hdr_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .RAM_valid (RAM_valid),
    .RAM_addr  (RAM_addr),
    .RAM_D     (RAM_D),
    .wr_cnt    (wr_cnt),
    .done      (done),
    .err_oob   (err_oob)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    hdr_valid = 1'b0;
    pix_valid = 1'b0;
    hdr_addr  = '0;
    hdr_data  = '0;
    pix_addr  = '0;
    pix_data  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic applyStimulus_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [33:0] obs;
    applyStimulus_reset();
    rst_n     = 1'b0;
    hdr_valid = 1'b1;
    pix_valid = 1'b1;
    #2;
    obs = {RAM_valid, RAM_addr, RAM_D, wr_cnt, done, err_oob, hdr_ready, pix_ready};
    n_checks++;
    if (obs !== 34'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h required 0", obs);
    end
    hdr_valid = 1'b0;
    pix_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hdr_writes();
    logic [12:0] obs0;
    logic [29:0] obs;
    logic [29:0] exp_v;
    logic [21:0] obs2;
    applyStimulus_reset();
    applyStimulus_start();
    obs0 = {RAM_valid, done, wr_cnt};
    n_checks++;
    if (obs0 !== 13'd0) begin
      n_fail++;
      $display("[TB] FAIL start_state: got %h required 0", obs0);
    end
    for (int a = 0; a < HDR; a++) begin
      hdr_valid = 1'b1;
      hdr_addr  = AW'(a);
      hdr_data  = DW'(a) ^ 8'h5A;
      #1;
      n_checks++;
      if (hdr_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL hdr_ready a=%0d: got %b required 1", a, hdr_ready);
      end
      tick();
      obs   = {RAM_valid, RAM_addr, RAM_D, wr_cnt};
      exp_v = {1'b1, AW'(a), DW'(a) ^ 8'h5A, 11'(a + 1)};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL hdr_write a=%0d: got %h required %h", a, obs, exp_v);
      end
    end
    hdr_valid = 1'b0;
    tick();
    obs2 = {RAM_valid, RAM_addr, wr_cnt};
    n_checks++;
    if (obs2 !== {1'b0, 10'd53, 11'd54}) begin
      n_fail++;
      $display("[TB] FAIL hdr_idle: got %h required %h", obs2, {1'b0, 10'd53, 11'd54});
    end
  endtask

  task automatic test_alternate();
    int hi;
    int pi;
    logic exp_h;
    logic [1:0] rdy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [18:0] obs;
    applyStimulus_reset();
    applyStimulus_start();
    hi = 0;
    pi = 0;
    hdr_valid = 1'b1;
    pix_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hdr_addr = AW'(hi);
      hdr_data = 8'hC0 + DW'(hi);
      pix_addr = AW'(pi);
      pix_data = 8'h30 + DW'(pi);
      exp_h = ((i % 2) == 0);
      #1;
      rdy = {hdr_ready, pix_ready};
      n_checks++;
      if (rdy !== {exp_h, !exp_h}) begin
        n_fail++;
        $display("[TB] FAIL alt_grant i=%0d: got %b required %b", i, rdy, {exp_h, !exp_h});
      end
      if (exp_h) begin
        e_addr = AW'(hi);
        e_data = 8'hC0 + DW'(hi);
        hi++;
      end else begin
        e_addr = AW'(pi + HDR);
        e_data = 8'h30 + DW'(pi);
        pi++;
      end
      tick();
      obs = {RAM_valid, RAM_addr, RAM_D};
      n_checks++;
      if (obs !== {1'b1, e_addr, e_data}) begin
        n_fail++;
        $display("[TB] FAIL alt_write i=%0d: got %h required %h", i, obs, {1'b1, e_addr, e_data});
      end
    end
    hdr_valid = 1'b0;
    pix_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_cnt !== 11'd8) begin
      n_fail++;
      $display("[TB] FAIL alt_count: got %0d required 8", wr_cnt);
    end
  endtask

  task automatic test_oob();
    logic [12:0] obs;
    logic [30:0] obs2;
    logic [11:0] obs3;
    pix_valid = 1'b1;
    pix_addr  = AW'(TOTAL - HDR);
    pix_data  = 8'hEE;
    #1;
    n_checks++;
    if (pix_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL oob_ready: got %b required 1", pix_ready);
    end
    tick();
    obs = {RAM_valid, err_oob, wr_cnt};
    n_checks++;
    if (obs !== {1'b0, 1'b1, 11'd8}) begin
      n_fail++;
      $display("[TB] FAIL oob_pix: got %h required %h", obs, {1'b0, 1'b1, 11'd8});
    end
    pix_addr = AW'(TOTAL - HDR - 1);
    pix_data = 8'h77;
    tick();
    obs2 = {RAM_valid, RAM_addr, RAM_D, err_oob, wr_cnt};
    n_checks++;
    if (obs2 !== {1'b1, 10'd821, 8'h77, 1'b1, 11'd9}) begin
      n_fail++;
      $display("[TB] FAIL last_addr: got %h required %h", obs2, {1'b1, 10'd821, 8'h77, 1'b1, 11'd9});
    end
    pix_valid = 1'b0;
    hdr_valid = 1'b1;
    hdr_addr  = AW'(TOTAL);
    hdr_data  = 8'h99;
    #1;
    n_checks++;
    if (hdr_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL oob_hdr_ready: got %b required 1", hdr_ready);
    end
    tick();
    hdr_valid = 1'b0;
    obs3 = {RAM_valid, wr_cnt};
    n_checks++;
    if (obs3 !== {1'b0, 11'd9}) begin
      n_fail++;
      $display("[TB] FAIL oob_hdr: got %h required %h", obs3, {1'b0, 11'd9});
    end
    tick();
    n_checks++;
    if ({err_oob, RAM_valid, RAM_addr} !== {1'b1, 1'b0, 10'd821}) begin
      n_fail++;
      $display("[TB] FAIL oob_sticky: got %h required %h", {err_oob, RAM_valid, RAM_addr}, {1'b1, 1'b0, 10'd821});
    end
  endtask

  task automatic test_start_ignored();
    logic [30:0] obs;
    hdr_valid = 1'b1;
    hdr_addr  = 10'd5;
    hdr_data  = 8'h12;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    hdr_valid = 1'b0;
    obs = {RAM_valid, RAM_addr, RAM_D, wr_cnt, err_oob};
    n_checks++;
    if (obs !== {1'b1, 10'd5, 8'h12, 11'd10, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL start_in_run: got %h required %h", obs, {1'b1, 10'd5, 8'h12, 11'd10, 1'b1});
    end
    tick();
  endtask

  task automatic test_full_pass();
    logic [19:0] obs;
    logic [19:0] exp_v;
    logic [12:0] obs2;
    logic [1:0]  rdy;
    applyStimulus_reset();
    applyStimulus_start();
    pix_valid = 1'b1;
    pix_addr  = AW'(TOTAL - HDR);
    tick();
    pix_valid = 1'b0;
    n_checks++;
    if ({err_oob, wr_cnt} !== {1'b1, 11'd0}) begin
      n_fail++;
      $display("[TB] FAIL full_pre_oob: got %h required %h", {err_oob, wr_cnt}, {1'b1, 11'd0});
    end
    for (int k = 0; k < TOTAL; k++) begin
      if (k < HDR) begin
        hdr_valid = 1'b1;
        pix_valid = 1'b0;
        hdr_addr  = AW'(k);
        hdr_data  = DW'(k);
      end else begin
        hdr_valid = 1'b0;
        pix_valid = 1'b1;
        pix_addr  = AW'(k - HDR);
        pix_data  = DW'(k);
      end
      tick();
      obs   = {RAM_valid, RAM_addr, RAM_D, done};
      exp_v = {1'b1, AW'(k), DW'(k), (k == TOTAL - 1)};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL full_write k=%0d: got %h required %h", k, obs, exp_v);
      end
    end
    hdr_valid = 1'b1;
    #1;
    rdy = {hdr_ready, pix_ready};
    n_checks++;
    if (rdy !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL done_ready: got %b required 00", rdy);
    end
    tick();
    obs2 = {RAM_valid, done, wr_cnt};
    n_checks++;
    if (obs2 !== {1'b0, 1'b1, 11'd822}) begin
      n_fail++;
      $display("[TB] FAIL done_hold: got %h required %h", obs2, {1'b0, 1'b1, 11'd822});
    end
    hdr_valid = 1'b0;
    pix_valid = 1'b0;
    applyStimulus_start();
    n_checks++;
    if ({done, err_oob, wr_cnt} !== 13'd0) begin
      n_fail++;
      $display("[TB] FAIL restart: got %h required 0", {done, err_oob, wr_cnt});
    end
    hdr_valid = 1'b1;
    hdr_addr  = '0;
    #1;
    n_checks++;
    if (hdr_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL restart_run: got %b required 1", hdr_ready);
    end
    hdr_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs;
    logic [1:0]  obs2;
    applyStimulus_reset();
    applyStimulus_start();
    hdr_valid = 1'b1;
    hdr_addr  = 10'd3;
    hdr_data  = 8'h33;
    tick();
    n_checks++;
    if ({RAM_valid, RAM_addr} !== {1'b1, 10'd3}) begin
      n_fail++;
      $display("[TB] FAIL mid_prewrite: got %h required %h", {RAM_valid, RAM_addr}, {1'b1, 10'd3});
    end
    hdr_addr = 10'd4;
    #2;
    rst_n = 1'b0;
    #1;
    obs = {RAM_valid, RAM_addr, RAM_D, wr_cnt, done, err_oob, hdr_ready};
    n_checks++;
    if (obs !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got %h required 0", obs);
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      obs2 = {RAM_valid, hdr_ready};
      n_checks++;
      if (obs2 !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL post_reset c=%0d: got %b required 00", c, obs2);
      end
    end
    hdr_valid = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_hdr_writes();
    test_alternate();
    test_oob();
    test_start_ignored();
    test_full_pass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bmp_ram_arbiter.md
BMP_RAM_ARBITER -- requirements
Module: bmp_ram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_W, default `ADDR_WIDTH: RAM address width.
REQ-003 Parameter DATA_W, default `BYTE_WIDTH: RAM data width.
REQ-004 Parameter TOTAL, default `BMP_TOTAL_SIZE: byte count of one complete image, header plus pixels.
REQ-005 Parameter PIX_OFFSET, default 54: header size in bytes, which is the base address of the pixel region.
REQ-006 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous reset, active low.
REQ-008 Port start, input, 1: single-cycle pulse that begins an image write pass.
REQ-009 Ports hdr_valid (input, 1), hdr_ready (output, 1), hdr_addr (input, ADDR_W), hdr_data (input, DATA_W): header requester; hdr_addr is an absolute RAM address.
REQ-010 Ports pix_valid (input, 1), pix_ready (output, 1), pix_addr (input, ADDR_W), pix_data (input, DATA_W): pixel requester; pix_addr is a pixel-byte index relative to PIX_OFFSET.
REQ-011 Ports RAM_valid (output, 1), RAM_addr (output, ADDR_W), RAM_D (output, DATA_W): write port to the BMP RAM.
REQ-012 Ports wr_cnt (output, ADDR_W+1), done (output, 1), err_oob (output, 1): accepted-write count, pass-complete flag, and sticky out-of-range flag.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE.
REQ-014 State transitions SHALL be: IDLE->RUN on start; RUN->DONE on the cycle the TOTAL-th in-range write is accepted; DONE->RUN on start.
REQ-015 On each IDLE->RUN or DONE->RUN transition, wr_cnt, err_oob and the round-robin pointer SHALL clear; done SHALL deassert.
REQ-016 In RUN, start SHALL be ignored.
REQ-017 hdr_ready and pix_ready SHALL be combinational, SHALL be asserted only in RUN, and at most one SHALL be high in any cycle.
REQ-018 In RUN with only one requester valid, that requester SHALL be granted.
REQ-019 In RUN with both requesters valid, the grant SHALL go to the requester not granted last; after reset or start, header SHALL win first.
REQ-020 A transfer SHALL occur when valid and ready are both high; the pointer SHALL update only on a transfer.
REQ-021 Target address SHALL be hdr_addr for a header transfer and pix_addr+PIX_OFFSET, computed at ADDR_W+1 bits, for a pixel transfer.
REQ-022 If the target address is below TOTAL, the next cycle SHALL show RAM_valid=1, RAM_addr=target, RAM_D=data. This is a fixed 1-cycle registered latency, with back-to-back writes every cycle.
REQ-023 If the target address is TOTAL or higher, the transfer SHALL still complete (ready high, no deadlock), RAM_valid SHALL stay 0, err_oob SHALL set and hold until the next start or reset, and wr_cnt SHALL NOT increment.
REQ-024 wr_cnt SHALL increment by 1 per in-range transfer and SHALL saturate at TOTAL.
REQ-025 done SHALL be registered, SHALL rise in the same cycle as the final RAM_valid pulse, and SHALL hold through DONE.
REQ-026 RAM_valid SHALL be 0 in any cycle without a transfer on the previous cycle; RAM_addr and RAM_D SHALL hold their last values.
REQ-027 A requester that keeps valid high while not ready SHALL be granted within 2 cycles in RUN (starvation bound).

Reset
REQ-028 Reset assertion SHALL be asynchronous; deassertion SHALL take effect on a clk edge.
REQ-029 On reset, state SHALL be IDLE and RAM_valid, RAM_addr, RAM_D, wr_cnt, done, err_oob, hdr_ready and pix_ready SHALL all be 0; the pointer SHALL favour header.
REQ-030 Reset mid-pass SHALL abort the pass with no further RAM writes; a pending registered write SHALL be dropped.

Structure
REQ-031 ADDR_WIDTH, BYTE_WIDTH and BMP_TOTAL_SIZE SHALL come from DEFINE.vh.
REQ-032 A BMP_HDR_SIZE constant (54) SHALL be added to DEFINE.vh and used as the PIX_OFFSET default.
REQ-033 State encodings SHALL be defined as local parameters within the module.
REQ-034 The module SHALL be a single flat module with no sub-modules; arbitration, counting and the output register are all small.

Verification
REQ-035 Bench SHALL cover: reset, start, hdr writes to addr 0..53 with pix idle -> 54 RAM_valid pulses at addr 0..53, 1-cycle latency, wr_cnt=54.
REQ-036 Bench SHALL cover: both valid continuously -> grants alternate H,P,H,P; pix_addr=0 appears as RAM_addr=54.
REQ-037 Bench SHALL cover: pix_addr=TOTAL-54 -> pix_ready=1, no RAM_valid, err_oob=1, wr_cnt unchanged.
REQ-038 Bench SHALL cover: TOTAL in-range writes -> done=1 with the final RAM_valid, both readies 0 after; start -> RUN, wr_cnt=0, done=0.
REQ-039 Bench SHALL cover: rst_n low mid-pass between clk edges -> outputs 0 immediately, no RAM_valid after release until the next start.
REQ-040 Bench SHALL cover: start pulsed during RUN -> ignored, wr_cnt continues.
